// File: rtl/rr_arb_mux_pkg.sv
// rr_arb_mux_pkg: shared definitions for the round-robin arbitrated mux.
//   DEF_WIDTH  : default per-channel data width
//   DEF_NUM_IN : default channel count
//   lock_e     : packet-lock state of the arbiter
package rr_arb_mux_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_NUM_IN = 8;

  typedef enum logic {
    LK_FREE = 1'b0,
    LK_HELD = 1'b1
  } lock_e;

endpackage

// File: rtl/rr_arb_mux_if.sv
// rr_arb_mux_if: producer/consumer bundle of the arbitrated mux.
//   in_valid/in_last/in_data/in_ready : NUM_IN producer channels, channel i in
//                                       in_data[i*WIDTH +: WIDTH]
//   out_valid/out_ready/out_data/out_sel/out_last : single consumer port
//   slave  : view taken by the mux
//   master : view taken by the surrounding producers/consumer
interface rr_arb_mux_if
  import rr_arb_mux_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned NUM_IN = DEF_NUM_IN
);
  localparam int unsigned SEL_W = $clog2(NUM_IN);

  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_last;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_last;

  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_last
  );

  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_last
  );
endinterface

// File: rtl/rr_arb_mux_pick.sv
// rr_pick: combinational round-robin picker.
//   req_i        : per-channel requests
//   ptr_i        : last granted channel; search starts at ptr_i+1
//   gnt_onehot_o : one-hot grant (zero when no request)
//   gnt_idx_o    : index of the granted channel (0 when no request)
//   any_o        : at least one request present
module rr_pick #(
  parameter int unsigned NUM_IN = 8,
  parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req_i,
  input  logic [SEL_W-1:0]  ptr_i,
  output logic [NUM_IN-1:0] gnt_onehot_o,
  output logic [SEL_W-1:0]  gnt_idx_o,
  output logic              any_o
);

  // Rotated fixed-priority search: step j examines channel (ptr+1+j) mod NUM_IN,
  // so the first hit is the winner and its index is already un-rotated.
  // ptr+1+j < 2*NUM_IN, so a single conditional subtract implements the modulo.
  always_comb begin
    int unsigned idx;
    gnt_onehot_o = '0;
    gnt_idx_o    = '0;
    any_o        = 1'b0;
    for (int unsigned j = 0; j < NUM_IN; j++) begin
      idx = 32'(ptr_i) + 32'd1 + j;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (!any_o && req_i[idx]) begin
        any_o             = 1'b1;
        gnt_onehot_o[idx] = 1'b1;
        gnt_idx_o         = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: NUM_IN-input round-robin arbitrated mux with a registered output
// stage and optional packet lock.
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : rr_arb_mux_if.slave (producer channels + consumer port)
// Parameters: WIDTH (data width), NUM_IN (channels), LOCK_EN (1 = hold the
// grant on a channel until a beat with in_last=1 is accepted).
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned NUM_IN  = DEF_NUM_IN,
  parameter bit          LOCK_EN = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  rr_arb_mux_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(NUM_IN);

  logic [WIDTH-1:0]  out_data_q;
  logic [SEL_W-1:0]  out_sel_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic [SEL_W-1:0]  last_grant_q;
  lock_e             lock_q, lock_d;

  logic              load_en;
  logic              xfer;
  logic [NUM_IN-1:0] lock_mask;
  logic [NUM_IN-1:0] req;
  logic [NUM_IN-1:0] gnt_onehot;
  logic [SEL_W-1:0]  gnt_idx;
  logic              any;
  logic [WIDTH-1:0]  win_data;
  logic              win_last;

  assign load_en = !out_valid_q || bus.out_ready;

  // While locked only the previously granted channel may compete.
  always_comb begin
    lock_mask               = '0;
    lock_mask[last_grant_q] = 1'b1;
    req = (lock_q == LK_HELD) ? (bus.in_valid & lock_mask) : bus.in_valid;
  end

  rr_pick #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_pick (
    .req_i        (req),
    .ptr_i        (last_grant_q),
    .gnt_onehot_o (gnt_onehot),
    .gnt_idx_o    (gnt_idx),
    .any_o        (any)
  );

  assign xfer         = load_en && any && !reset;
  assign bus.in_ready = xfer ? gnt_onehot : '0;

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (gnt_onehot[i]) win_data = bus.in_data[i*WIDTH +: WIDTH];
    end
    win_last = |(bus.in_last & gnt_onehot);
  end

  always_comb begin
    lock_d = lock_q;
    if (LOCK_EN && xfer) lock_d = win_last ? LK_FREE : LK_HELD;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lock_q <= LK_FREE;
    end else begin
      lock_q <= lock_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sel_q    <= '0;
      out_last_q   <= 1'b0;
      last_grant_q <= SEL_W'(NUM_IN - 1);
    end else if (xfer) begin
      out_valid_q  <= 1'b1;
      out_data_q   <= win_data;
      out_sel_q    <= gnt_idx;
      out_last_q   <= win_last;
      last_grant_q <= gnt_idx;
    end else if (load_en) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed self-checking bench. Instance u_a runs without packet
// lock, u_b with packet lock; both share one clock.
module tb_rr_arb_mux;
  localparam int unsigned W = 32;
  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rr_arb_mux_if #(.WIDTH(W), .NUM_IN(N)) bus_a ();
  rr_arb_mux_if #(.WIDTH(W), .NUM_IN(N)) bus_b ();

  rr_arb_mux #(.WIDTH(W), .NUM_IN(N), .LOCK_EN(1'b0)) u_a (
    .clock (clk),
    .reset (rst_a),
    .bus   (bus_a.slave)
  );

  rr_arb_mux #(.WIDTH(W), .NUM_IN(N), .LOCK_EN(1'b1)) u_b (
    .clock (clk),
    .reset (rst_b),
    .bus   (bus_b.slave)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.in_valid = '0; bus_a.in_last = '0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = '0; bus_b.in_last = '0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", 64'(bus_a.out_valid), 64'd0);
    check("rst_data",  64'(bus_a.out_data),  64'd0);
    check("rst_sel",   64'(bus_a.out_sel),   64'd0);
    check("rst_last",  64'(bus_a.out_last),  64'd0);
    check("rst_ready", 64'(bus_a.in_ready),  64'd0);

    // Fairness sweep: all channels valid, consumer always ready.
    rst_a = 1'b0;
    for (int i = 0; i < 8; i++) bus_a.in_data[i*32 +: 32] = 32'hA0 + 32'(i);
    bus_a.in_valid  = 8'hFF;
    bus_a.out_ready = 1'b1;
    #1;
    check("rr_first_ready", 64'(bus_a.in_ready), 64'h01);
    for (int k = 0; k < 9; k++) begin
      tick();
      check("rr_sel",   64'(bus_a.out_sel),   64'(k % 8));
      check("rr_data",  64'(bus_a.out_data),  64'(32'hA0 + 32'(k % 8)));
      check("rr_valid", 64'(bus_a.out_valid), 64'd1);
    end

    // Single requester on channel 5.
    bus_a.in_valid = 8'h20;
    bus_a.in_data[5*32 +: 32] = 32'hDEAD_BEEF;
    #1;
    check("ch5_ready", 64'(bus_a.in_ready), 64'h20);
    tick();
    check("ch5_data", 64'(bus_a.out_data), 64'hDEAD_BEEF);
    check("ch5_sel",  64'(bus_a.out_sel),  64'd5);

    // Backpressure with every channel requesting.
    bus_a.in_valid  = 8'hFF;
    bus_a.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ready", 64'(bus_a.in_ready), 64'h00);
      tick();
      check("bp_data",  64'(bus_a.out_data),  64'hDEAD_BEEF);
      check("bp_sel",   64'(bus_a.out_sel),   64'd5);
      check("bp_valid", 64'(bus_a.out_valid), 64'd1);
    end
    bus_a.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(bus_a.in_ready), 64'h40);
    tick();
    check("bp_release_sel",  64'(bus_a.out_sel),  64'd6);
    check("bp_release_data", 64'(bus_a.out_data), 64'hA6);

    // Wrap 7 -> 0, then idle.
    bus_a.in_valid = 8'h80;
    tick();
    check("wrap_sel7", 64'(bus_a.out_sel), 64'd7);
    bus_a.in_valid = 8'h01;
    #1;
    check("wrap_ready0", 64'(bus_a.in_ready), 64'h01);
    tick();
    check("wrap_sel0",  64'(bus_a.out_sel),  64'd0);
    check("wrap_data0", 64'(bus_a.out_data), 64'hA0);
    bus_a.in_valid = 8'h00;
    #1;
    check("idle_ready", 64'(bus_a.in_ready), 64'h00);
    tick();
    check("idle_valid", 64'(bus_a.out_valid), 64'd0);
    check("idle_data",  64'(bus_a.out_data),  64'hA0);
    check("idle_sel",   64'(bus_a.out_sel),   64'd0);

    // Packet lock: channel 2 sends three beats while channel 3 also requests.
    rst_b = 1'b0;
    bus_b.out_ready = 1'b1;
    bus_b.in_data[3*32 +: 32] = 32'h0000_0300;
    bus_b.in_last = 8'h08;
    for (int b = 0; b < 3; b++) begin
      bus_b.in_valid = 8'h0C;
      bus_b.in_data[2*32 +: 32] = 32'h0000_0200 + 32'(b);
      bus_b.in_last[2] = (b == 2);
      #1;
      check("lock_ready", 64'(bus_b.in_ready), 64'h04);
      tick();
      check("lock_sel",  64'(bus_b.out_sel),  64'd2);
      check("lock_data", 64'(bus_b.out_data), 64'(32'h200 + 32'(b)));
      check("lock_last", 64'(bus_b.out_last), 64'(b == 2));
    end
    bus_b.in_last[2] = 1'b0;
    tick();
    check("unlock_sel",  64'(bus_b.out_sel),  64'd3);
    check("unlock_data", 64'(bus_b.out_data), 64'h300);

    // Reset in the middle of a locked packet with a word held.
    bus_b.in_valid = 8'h04;
    tick();
    check("pre_rst_sel",   64'(bus_b.out_sel),   64'd2);
    check("pre_rst_valid", 64'(bus_b.out_valid), 64'd1);
    rst_b = 1'b1;
    bus_b.in_valid = 8'h0E;
    #1;
    check("rst_mid_ready", 64'(bus_b.in_ready), 64'h00);
    tick();
    check("rst_mid_valid", 64'(bus_b.out_valid), 64'd0);
    check("rst_mid_data",  64'(bus_b.out_data),  64'd0);
    rst_b = 1'b0;
    bus_b.in_valid = 8'h0A;
    bus_b.in_last  = 8'hFF;
    bus_b.in_data[1*32 +: 32] = 32'h0000_0100;
    #1;
    check("post_rst_ready", 64'(bus_b.in_ready), 64'h02);
    tick();
    check("post_rst_sel",  64'(bus_b.out_sel),  64'd1);
    check("post_rst_data", 64'(bus_b.out_data), 64'h100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
